axi_wr_arbiter: RTL and testbench
=================================

Name: axi_wr_arbiter

Overview:
- Round-robin arbiter that shares one AXI write path (AW/W/B) of the AXI slave among NUM_M upstream masters.
- Grants one master per burst and routes that master's AW, its W beats and the returning B response.
- Re-arbitrates only after the B handshake. Exactly one write burst is outstanding at the slave at any time.
- Sits between the interconnect masters and the slave's write channels.

Parameters:
- NUM_M, 2, number of upstream masters (2..8).
- ADDR_BITS, 32, address width.
- DATA_BITS, 32, data width; strobe width is DATA_BITS/8.
- LEN_BITS, 8, burst length width (beats = len+1).
- SIZE_BITS, 3, burst size width.

Ports:
- aclk  input  1  clock.
- areset_n  input  1  asynchronous active-low reset.
- up_aw_valid/up_aw_ready  in/out  NUM_M each  per-master AW handshake.
- up_aw_addr/len/size/burst/cache  input  NUM_M x {ADDR_BITS,LEN_BITS,SIZE_BITS,2,4}  per-master AW payload.
- up_w_valid/up_w_last  input  NUM_M each  per-master W valid/last.
- up_w_ready  output  NUM_M  per-master W ready.
- up_w_data/up_w_strb  input  NUM_M x {DATA_BITS,DATA_BITS/8}  per-master W payload.
- up_b_valid  output  NUM_M  per-master B valid.
- up_b_ready  input  NUM_M  per-master B ready.
- up_b_resp  output  2  B response, shared by all masters; qualified by up_b_valid.
- dn_aw_valid/addr/len/size/burst/cache  output  1/ADDR_BITS/LEN_BITS/SIZE_BITS/2/4  AW to slave.
- dn_aw_ready  input  1.
- dn_w_valid/data/strb/last  output  1/DATA_BITS/DATA_BITS/8/1  W to slave.
- dn_w_ready  input  1.
- dn_b_valid/resp  input  1/2  B from slave.
- dn_b_ready  output  1.
- grant_id  output  clog2(NUM_M)  index of the granted master; valid when busy=1.
- busy  output  1  high outside IDLE.

Behaviour:
- Reset (areset_n=0, asynchronous):
  - FSM goes to IDLE; rr pointer = 0; grant_id = 0.
  - busy, all up_*_ready, up_b_valid, dn_aw_valid, dn_w_valid and dn_b_ready = 0.
  - Reset mid-burst abandons the burst; no completion is emitted.
- FSM IDLE -> AW -> DATA -> RESP -> IDLE.
- IDLE:
  - If any up_aw_valid is set, pick the first requester at or after the rr pointer (modulo NUM_M).
  - Register grant_id and go to AW. One cycle of grant latency: request in cycle N, dn_aw_valid in N+1.
- AW:
  - Drive dn_aw_* from the granted master; up_aw_ready[g] = dn_aw_ready; all other up_aw_ready = 0.
  - On the dn_aw_valid & dn_aw_ready handshake, capture len and go to DATA.
  - AW payload must remain stable while waiting.
- DATA:
  - Pass W combinationally: dn_w_* = up_w_*[g]; up_w_ready[g] = dn_w_ready; other masters' ready = 0.
  - On a handshake with w_last, go to RESP.
  - W beats offered by the granted master before its AW handshake are not accepted (no W-before-AW support).
- RESP:
  - up_b_valid[g] = dn_b_valid; up_b_resp = dn_b_resp; dn_b_ready = up_b_ready[g].
  - On the handshake: rr pointer = g+1 (wrap to 0 at NUM_M), go to IDLE.
- Back-to-back bursts: at least one IDLE cycle between a B handshake and the next AW.
- Ungranted masters hold their requests; the next grant is decided in IDLE using the updated pointer.
- Simultaneous requests: priority is rotating, never fixed. Starvation bound is NUM_M bursts.
- No combinational path from up_*_valid to up_*_ready of a different master.

Optional Feature:
- Macro AXI_WR_ARB_LEN_CHECK_EN.
- Defined:
  - A beat counter (LEN_BITS+1 wide) counts W handshakes.
  - If w_last arrives on a beat other than len+1, or beat len+1 lacks w_last, a sticky flag is set and the up_b_resp returned to the master is forced to SLVERR (2'b10).
  - Extra output len_err pulses 1 cycle on detection.
  - A missing w_last is passed through and the burst still ends on the master's w_last.
- Undefined: no counter; w_last is trusted; up_b_resp = dn_b_resp; len_err port absent.

Decomposition:
- Shared package axi_pkg:
  - Burst encodings FIXED/INCR/WRAP.
  - Response encodings OKAY/EXOKAY/SLVERR/DECERR.
  - Width constants aligned to the slave's widths.
  - arb_state_e enum {IDLE, AW, DATA, RESP}.
- One sub-module rr_picker (combinational request vector + pointer -> one-hot grant + index), reusable by the read-side arbiter.

Test Plan:
- Single master 0, len=3, all readies 1 -> grant_id=0, busy from cycle 1, dn_aw_valid at cycle 1, 4 W beats forwarded, OKAY returned to master 0 only.
- Masters 0 and 1 request together repeatedly with pointer=0 -> grant order 0,1,0,1; master 1's up_aw_ready stays 0 while master 0 owns the path.
- dn_w_ready toggles 1/0 every cycle during an 8-beat burst -> exactly 8 handshakes, payload order preserved, no beat duplicated or dropped.
- dn_b_valid held while up_b_ready[g]=0 for 5 cycles -> FSM stays in RESP, pointer unchanged, completes when ready rises.
- areset_n asserted in DATA after 2 of 4 beats -> all outputs 0 immediately, pointer 0, a fresh request is granted cleanly after release.
- With AXI_WR_ARB_LEN_CHECK_EN, len=3 but w_last on beat 2 -> len_err pulses, master receives b_resp=2'b10 although the slave returns OKAY.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the write-path arbiter (and its read-side sibling):
// burst/response encodings, slave-aligned width constants, the arbiter FSM
// state type and the round-robin pointer advance helper.
package axi_pkg;

    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 8;
    localparam int AXI_SIZE_BITS = 3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        AW   = 2'b01,
        DATA = 2'b10,
        RESP = 2'b11
    } arb_state_e;

    // Pointer value after master idx completes: the next master, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/axi_wr_arbiter_rr_picker.sv
// rr_picker: purely combinational round-robin selection. Scans the request
// vector starting at the pointer (wrapping modulo N) and returns the first
// requester as a one-hot vector and as an index.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic          w_found;
    int            w_cand;
    logic [IW-1:0] w_cand_idx;

    // Walk candidates ptr, ptr+1, ... and lock onto the first active request.
    always_comb begin
        o_gnt      = '0;
        o_idx      = '0;
        w_found    = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = int'(i_ptr) + i;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end else begin
                w_cand = w_cand;
            end
            w_cand_idx = IW'(w_cand);
            if (!w_found && i_req[w_cand_idx]) begin
                w_found           = 1'b1;
                o_gnt[w_cand_idx] = 1'b1;
                o_idx             = w_cand_idx;
            end else begin
                w_found = w_found;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin sharing of one AXI write path (AW/W/B) among
// NUM_M masters. One burst at a time: grant in IDLE, forward AW, stream W
// until w_last, return B, then advance the pointer past the winner.
// Optional build macro AXI_WR_ARB_LEN_CHECK_EN adds a W beat counter that
// flags bursts whose w_last disagrees with len, forcing SLVERR upstream and
// pulsing len_err.
module axi_wr_arbiter
    import axi_pkg::*;
#(
    parameter int NUM_M     = 2,
    parameter int ADDR_BITS = AXI_ADDR_BITS,
    parameter int DATA_BITS = AXI_DATA_BITS,
    parameter int LEN_BITS  = AXI_LEN_BITS,
    parameter int SIZE_BITS = AXI_SIZE_BITS
) (
    input  logic                                  aclk,
    input  logic                                  areset_n,
    // upstream AW
    input  logic [NUM_M-1:0]                      up_aw_valid,
    output logic [NUM_M-1:0]                      up_aw_ready,
    input  logic [NUM_M-1:0][ADDR_BITS-1:0]       up_aw_addr,
    input  logic [NUM_M-1:0][LEN_BITS-1:0]        up_aw_len,
    input  logic [NUM_M-1:0][SIZE_BITS-1:0]       up_aw_size,
    input  logic [NUM_M-1:0][1:0]                 up_aw_burst,
    input  logic [NUM_M-1:0][3:0]                 up_aw_cache,
    // upstream W
    input  logic [NUM_M-1:0]                      up_w_valid,
    input  logic [NUM_M-1:0]                      up_w_last,
    output logic [NUM_M-1:0]                      up_w_ready,
    input  logic [NUM_M-1:0][DATA_BITS-1:0]       up_w_data,
    input  logic [NUM_M-1:0][DATA_BITS/8-1:0]     up_w_strb,
    // upstream B
    output logic [NUM_M-1:0]                      up_b_valid,
    input  logic [NUM_M-1:0]                      up_b_ready,
    output logic [1:0]                            up_b_resp,
    // downstream AW
    output logic                                  dn_aw_valid,
    output logic [ADDR_BITS-1:0]                  dn_aw_addr,
    output logic [LEN_BITS-1:0]                   dn_aw_len,
    output logic [SIZE_BITS-1:0]                  dn_aw_size,
    output logic [1:0]                            dn_aw_burst,
    output logic [3:0]                            dn_aw_cache,
    input  logic                                  dn_aw_ready,
    // downstream W
    output logic                                  dn_w_valid,
    output logic [DATA_BITS-1:0]                  dn_w_data,
    output logic [DATA_BITS/8-1:0]                dn_w_strb,
    output logic                                  dn_w_last,
    input  logic                                  dn_w_ready,
    // downstream B
    input  logic                                  dn_b_valid,
    input  logic [1:0]                            dn_b_resp,
    output logic                                  dn_b_ready,
    // status
`ifdef AXI_WR_ARB_LEN_CHECK_EN
    output logic                                  len_err,
`endif
    output logic [((NUM_M > 1) ? $clog2(NUM_M) : 1)-1:0] grant_id,
    output logic                                  busy
);

    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    arb_state_e       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_grant, w_grant_nxt;
    logic [NUM_M-1:0] r_grant_oh, w_grant_oh_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
    logic             r_busy;

    logic [NUM_M-1:0] w_pick_oh;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;

    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_w_last_hs;
    logic             w_b_hs;

    rr_picker #(
        .N  (NUM_M),
        .IW (IDX_W)
    ) u_picker (
        .i_req (up_aw_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_oh),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_aw_hs     = (r_state == AW) & dn_aw_ready;
    assign w_w_hs      = (r_state == DATA) & up_w_valid[r_grant] & dn_w_ready;
    assign w_w_last_hs = w_w_hs & up_w_last[r_grant];
    assign w_b_hs      = (r_state == RESP) & dn_b_valid & up_b_ready[r_grant];

    // State, grant and pointer registers; reset abandons any burst in flight.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_ptr      <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_oh <= w_grant_oh_nxt;
            r_ptr      <= w_ptr_nxt;
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    // Next-state logic: grant in IDLE, advance on each channel's handshake.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_oh_nxt = r_grant_oh;
        w_ptr_nxt      = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt    = AW;
                    w_grant_nxt    = w_pick_idx;
                    w_grant_oh_nxt = w_pick_oh;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            AW: begin
                if (w_aw_hs) begin
                    w_state_nxt = DATA;
                end else begin
                    w_state_nxt = AW;
                end
            end
            DATA: begin
                if (w_w_last_hs) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = DATA;
                end
            end
            RESP: begin
                if (w_b_hs) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = IDX_W'(rr_next(32'(r_grant), 32'(NUM_M)));
                end else begin
                    w_state_nxt = RESP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Channel routing: only the granted master's handshake is ever exposed,
    // and only in the state that owns that channel.
    always_comb begin
        dn_aw_valid = 1'b0;
        dn_aw_addr  = up_aw_addr[r_grant];
        dn_aw_len   = up_aw_len[r_grant];
        dn_aw_size  = up_aw_size[r_grant];
        dn_aw_burst = up_aw_burst[r_grant];
        dn_aw_cache = up_aw_cache[r_grant];
        up_aw_ready = '0;
        dn_w_valid  = 1'b0;
        dn_w_data   = up_w_data[r_grant];
        dn_w_strb   = up_w_strb[r_grant];
        dn_w_last   = up_w_last[r_grant];
        up_w_ready  = '0;
        up_b_valid  = '0;
        dn_b_ready  = 1'b0;
        case (r_state)
            AW: begin
                dn_aw_valid = 1'b1;
                up_aw_ready = r_grant_oh & {NUM_M{dn_aw_ready}};
            end
            DATA: begin
                dn_w_valid = up_w_valid[r_grant];
                up_w_ready = r_grant_oh & {NUM_M{dn_w_ready}};
            end
            RESP: begin
                up_b_valid = r_grant_oh & {NUM_M{dn_b_valid}};
                dn_b_ready = up_b_ready[r_grant];
            end
            default: begin
                dn_aw_valid = 1'b0;
            end
        endcase
    end

`ifdef AXI_WR_ARB_LEN_CHECK_EN
    logic [LEN_BITS-1:0] r_len;
    logic [LEN_BITS:0]   r_beat;
    logic                r_err;
    logic                r_len_err;
    logic                w_beat_bad;

    // A beat is bad when its w_last disagrees with "this is beat len+1".
    assign w_beat_bad = w_w_hs & (up_w_last[r_grant] != (r_beat == {1'b0, r_len}));

    // Beat counter and sticky error, re-armed at every AW handshake.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_len     <= '0;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_len_err <= 1'b0;
        end else if (w_aw_hs) begin
            r_len     <= up_aw_len[r_grant];
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            if (w_w_hs) begin
                r_beat <= r_beat + {{LEN_BITS{1'b0}}, 1'b1};
            end else begin
                r_beat <= r_beat;
            end
            r_err     <= r_err | w_beat_bad;
            r_len_err <= w_beat_bad & ~r_err;
        end
    end

    // Upstream response: SLVERR overrides the slave once a length error is seen.
    always_comb begin
        if (r_err) begin
            up_b_resp = RESP_SLVERR;
        end else begin
            up_b_resp = dn_b_resp;
        end
    end

    assign len_err = r_len_err;
`else
    assign up_b_resp = dn_b_resp;
`endif

    assign grant_id = r_grant;
    assign busy     = r_busy;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter (NUM_M=2). Stimulus pushes the expected
// AW/W/B traffic into queues; a monitor pops and compares on each handshake.
module tb_axi_wr_arbiter;

    localparam int NUM_M = 2;

    logic                    aclk;
    logic                    areset_n;
    logic [NUM_M-1:0]        up_aw_valid, up_aw_ready;
    logic [NUM_M-1:0][31:0]  up_aw_addr;
    logic [NUM_M-1:0][7:0]   up_aw_len;
    logic [NUM_M-1:0][2:0]   up_aw_size;
    logic [NUM_M-1:0][1:0]   up_aw_burst;
    logic [NUM_M-1:0][3:0]   up_aw_cache;
    logic [NUM_M-1:0]        up_w_valid, up_w_last, up_w_ready;
    logic [NUM_M-1:0][31:0]  up_w_data;
    logic [NUM_M-1:0][3:0]   up_w_strb;
    logic [NUM_M-1:0]        up_b_valid, up_b_ready;
    logic [1:0]              up_b_resp;
    logic                    dn_aw_valid, dn_aw_ready;
    logic [31:0]             dn_aw_addr;
    logic [7:0]              dn_aw_len;
    logic [2:0]              dn_aw_size;
    logic [1:0]              dn_aw_burst;
    logic [3:0]              dn_aw_cache;
    logic                    dn_w_valid, dn_w_ready, dn_w_last;
    logic [31:0]             dn_w_data;
    logic [3:0]              dn_w_strb;
    logic                    dn_b_valid, dn_b_ready;
    logic [1:0]              dn_b_resp;
    logic [0:0]              grant_id;
    logic                    busy;
`ifdef AXI_WR_ARB_LEN_CHECK_EN
    logic                    len_err;
`endif

    int total = 0;
    int bad   = 0;
    int w_hs_cnt = 0;
    int len_err_cnt = 0;
    logic w_toggle = 1'b0;

    logic [47:0] exp_aw[$];   // {master[7:0], addr, len}
    logic [32:0] exp_w[$];    // {last, data}
    logic [9:0]  exp_b[$];    // {master[7:0], resp}

    axi_wr_arbiter #(.NUM_M(NUM_M)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .up_aw_valid(up_aw_valid), .up_aw_ready(up_aw_ready),
        .up_aw_addr(up_aw_addr), .up_aw_len(up_aw_len), .up_aw_size(up_aw_size),
        .up_aw_burst(up_aw_burst), .up_aw_cache(up_aw_cache),
        .up_w_valid(up_w_valid), .up_w_last(up_w_last), .up_w_ready(up_w_ready),
        .up_w_data(up_w_data), .up_w_strb(up_w_strb),
        .up_b_valid(up_b_valid), .up_b_ready(up_b_ready), .up_b_resp(up_b_resp),
        .dn_aw_valid(dn_aw_valid), .dn_aw_addr(dn_aw_addr), .dn_aw_len(dn_aw_len),
        .dn_aw_size(dn_aw_size), .dn_aw_burst(dn_aw_burst), .dn_aw_cache(dn_aw_cache),
        .dn_aw_ready(dn_aw_ready),
        .dn_w_valid(dn_w_valid), .dn_w_data(dn_w_data), .dn_w_strb(dn_w_strb),
        .dn_w_last(dn_w_last), .dn_w_ready(dn_w_ready),
        .dn_b_valid(dn_b_valid), .dn_b_resp(dn_b_resp), .dn_b_ready(dn_b_ready),
`ifdef AXI_WR_ARB_LEN_CHECK_EN
        .len_err(len_err),
`endif
        .grant_id(grant_id), .busy(busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=event required=no_event", name);
    endtask

    task automatic push_burst(input int m, input logic [31:0] addr, input logic [7:0] len,
                              input logic [31:0] dbase, input int last_at, input logic [1:0] resp);
        exp_aw.push_back({8'(m), addr, len});
        for (int bt = 0; bt <= last_at; bt++) begin
            exp_w.push_back({(bt == last_at), dbase + 32'(bt)});
        end
        exp_b.push_back({8'(m), resp});
    endtask

    task automatic master_burst(input int m, input logic [31:0] addr, input logic [7:0] len,
                                input logic [31:0] dbase, input int last_at, input int b_delay);
        int n;
        @(posedge aclk); #1;
        up_aw_valid[m] = 1'b1;
        up_aw_addr[m]  = addr;
        up_aw_len[m]   = len;
        up_aw_size[m]  = 3'd2;
        up_aw_burst[m] = 2'b01;
        up_aw_cache[m] = 4'd0;
        n = 0;
        do begin @(negedge aclk); n++; end while (!up_aw_ready[m] && n < 300);
        if (!up_aw_ready[m]) begin
            fail_now($sformatf("aw_timeout_m%0d", m));
            up_aw_valid[m] = 1'b0;
            return;
        end
        @(posedge aclk); #1;
        up_aw_valid[m] = 1'b0;
        for (int bt = 0; bt <= last_at; bt++) begin
            up_w_valid[m] = 1'b1;
            up_w_data[m]  = dbase + 32'(bt);
            up_w_strb[m]  = 4'hF;
            up_w_last[m]  = (bt == last_at);
            n = 0;
            do begin @(negedge aclk); n++; end while (!up_w_ready[m] && n < 300);
            if (!up_w_ready[m]) begin
                fail_now($sformatf("w_timeout_m%0d", m));
                up_w_valid[m] = 1'b0;
                return;
            end
            @(posedge aclk); #1;
        end
        up_w_valid[m] = 1'b0;
        up_w_last[m]  = 1'b0;
        for (int d = 0; d < b_delay; d++) begin
            @(negedge aclk);
            chk("b_stall_busy", {63'd0, busy}, 64'd1);
            chk("b_stall_dn_b_ready", {63'd0, dn_b_ready}, 64'd0);
        end
        @(posedge aclk); #1;
        up_b_ready[m] = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!up_b_valid[m] && n < 300);
        if (!up_b_valid[m]) fail_now($sformatf("b_timeout_m%0d", m));
        @(posedge aclk); #1;
        up_b_ready[m] = 1'b0;
    endtask

    // Slave model: always ready on AW, optional toggling W ready, OKAY B after w_last.
    initial begin : slave
        logic last_hs, b_hs;
        dn_aw_ready = 1'b1;
        dn_w_ready  = 1'b1;
        dn_b_valid  = 1'b0;
        dn_b_resp   = 2'b00;
        forever begin
            @(negedge aclk);
            last_hs = dn_w_valid & dn_w_ready & dn_w_last;
            b_hs    = dn_b_valid & dn_b_ready;
            @(posedge aclk); #1;
            if (!areset_n) begin
                dn_b_valid = 1'b0;
            end else begin
                if (b_hs) dn_b_valid = 1'b0;
                if (last_hs) dn_b_valid = 1'b1;
            end
            dn_w_ready = w_toggle ? ~dn_w_ready : 1'b1;
        end
    end

    // Monitor: compare every handshake against the scoreboard queues.
    initial begin : monitor
        logic [47:0] a;
        logic [32:0] w;
        logic [9:0]  b;
        logic [NUM_M-1:0] gm;
        logic prev_b_hs;
        int bm;
        prev_b_hs = 1'b0;
        forever begin
            @(negedge aclk);
            if (!areset_n) begin
                prev_b_hs = 1'b0;
            end else begin
`ifdef AXI_WR_ARB_LEN_CHECK_EN
                if (len_err) len_err_cnt++;
`endif
                if (prev_b_hs) begin
                    chk("idle_gap_aw_valid", {63'd0, dn_aw_valid}, 64'd0);
                    chk("idle_gap_busy", {63'd0, busy}, 64'd0);
                end
                prev_b_hs = 1'b0;
                if (busy) begin
                    gm = '0;
                    gm[grant_id] = 1'b1;
                    chk("other_master_ready", {58'd0, up_aw_ready & ~gm, up_w_ready & ~gm, up_b_valid & ~gm}, 64'd0);
                end
                if (dn_aw_valid && dn_aw_ready) begin
                    if (exp_aw.size() == 0) fail_now("aw_unexpected");
                    else begin
                        a = exp_aw.pop_front();
                        chk("aw_grant_id", {63'd0, grant_id}, {56'd0, a[47:40]});
                        chk("aw_addr", {32'd0, dn_aw_addr}, {32'd0, a[39:8]});
                        chk("aw_len", {56'd0, dn_aw_len}, {56'd0, a[7:0]});
                        chk("aw_busy", {63'd0, busy}, 64'd1);
                    end
                end
                if (dn_w_valid && dn_w_ready) begin
                    w_hs_cnt++;
                    if (exp_w.size() == 0) fail_now("w_unexpected");
                    else begin
                        w = exp_w.pop_front();
                        chk("w_beat", {31'd0, dn_w_last, dn_w_data}, {31'd0, w});
                        chk("w_strb", {60'd0, dn_w_strb}, 64'hF);
                    end
                end
                if ((up_b_valid & up_b_ready) != '0) begin
                    prev_b_hs = 1'b1;
                    bm = up_b_valid[1] ? 1 : 0;
                    chk("b_onehot", 64'($countones(up_b_valid)), 64'd1);
                    if (exp_b.size() == 0) fail_now("b_unexpected");
                    else begin
                        b = exp_b.pop_front();
                        chk("b_master", 64'(bm), {56'd0, b[9:2]});
                        chk("b_resp", {62'd0, up_b_resp}, {62'd0, b[1:0]});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic both_burst(input int first, input logic [31:0] abase);
        int second;
        second = 1 - first;
        push_burst(first,  abase + 32'h10 * 32'(first),  8'd1, abase + 32'h100 * 32'(first + 1), 1, 2'b00);
        push_burst(second, abase + 32'h10 * 32'(second), 8'd1, abase + 32'h100 * 32'(second + 1), 1, 2'b00);
        fork
            master_burst(0, abase,         8'd1, abase + 32'h100, 1, 0);
            master_burst(1, abase + 32'h10, 8'd1, abase + 32'h200, 1, 0);
        join
    endtask

    initial begin : stim
        int n0;
        int n;
        areset_n    = 1'b0;
        up_aw_valid = '0; up_aw_addr = '0; up_aw_len = '0; up_aw_size = '0;
        up_aw_burst = '0; up_aw_cache = '0;
        up_w_valid = '0; up_w_last = '0; up_w_data = '0; up_w_strb = '0;
        up_b_ready = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_grant_id", {63'd0, grant_id}, 64'd0);
        chk("rst_outputs", {59'd0, dn_aw_valid, dn_w_valid, dn_b_ready, |up_aw_ready, |up_w_ready}, 64'd0);
        chk("rst_up_b_valid", {62'd0, up_b_valid}, 64'd0);
        @(posedge aclk); #1;
        areset_n = 1'b1;

        // single master 0, len=3, one-cycle grant latency
        push_burst(0, 32'h1000, 8'd3, 32'hA000_0000, 3, 2'b00);
        fork
            master_burst(0, 32'h1000, 8'd3, 32'hA000_0000, 3, 0);
            begin
                @(posedge aclk);
                @(negedge aclk);
                chk("lat_cycle_n_aw_valid", {63'd0, dn_aw_valid}, 64'd0);
                chk("lat_cycle_n_busy", {63'd0, busy}, 64'd0);
                @(negedge aclk);
                chk("lat_cycle_n1_aw_valid", {63'd0, dn_aw_valid}, 64'd1);
                chk("lat_cycle_n1_busy", {63'd0, busy}, 64'd1);
                chk("lat_cycle_n1_grant", {63'd0, grant_id}, 64'd0);
            end
        join

        // 8-beat burst from master 1 with toggling dn_w_ready (pointer now 1)
        @(posedge aclk); #1;
        w_toggle = 1'b1;
        n0 = w_hs_cnt;
        push_burst(1, 32'h2000, 8'd7, 32'hB000_0000, 7, 2'b00);
        master_burst(1, 32'h2000, 8'd7, 32'hB000_0000, 7, 0);
        chk("toggle_hs_count", 64'(w_hs_cnt - n0), 64'd8);
        chk("toggle_w_drained", 64'(exp_w.size()), 64'd0);
        @(posedge aclk); #1;
        w_toggle = 1'b0;

        // simultaneous requests with pointer 0 -> 0,1,0,1
        both_burst(0, 32'h3000);
        both_burst(0, 32'h3400);

        // B stalled 5 cycles for master 0, then pointer 1 -> 1 wins next
        push_burst(0, 32'h4000, 8'd0, 32'hC000_0000, 0, 2'b00);
        master_burst(0, 32'h4000, 8'd0, 32'hC000_0000, 0, 5);
        both_burst(1, 32'h4400);

        // reset in DATA after 2 of 4 beats of master 0
        exp_aw.push_back({8'd0, 32'h5000, 8'd3});
        exp_w.push_back({1'b0, 32'hD000_0000});
        exp_w.push_back({1'b0, 32'hD000_0001});
        @(posedge aclk); #1;
        up_aw_valid[0] = 1'b1; up_aw_addr[0] = 32'h5000; up_aw_len[0] = 8'd3;
        n = 0;
        do begin @(negedge aclk); n++; end while (!up_aw_ready[0] && n < 300);
        if (!up_aw_ready[0]) fail_now("rst_test_aw_timeout");
        @(posedge aclk); #1;
        up_aw_valid[0] = 1'b0;
        for (int bt = 0; bt < 2; bt++) begin
            up_w_valid[0] = 1'b1; up_w_data[0] = 32'hD000_0000 + 32'(bt);
            up_w_strb[0] = 4'hF; up_w_last[0] = 1'b0;
            @(negedge aclk);
            chk("rst_test_w_ready", {63'd0, up_w_ready[0]}, 64'd1);
            @(posedge aclk); #1;
        end
        up_w_data[0] = 32'hD000_0002;
        #2;
        areset_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_grant_id", {63'd0, grant_id}, 64'd0);
        chk("midrst_outputs", {59'd0, dn_aw_valid, dn_w_valid, dn_b_ready, |up_aw_ready, |up_w_ready}, 64'd0);
        @(posedge aclk); #1;
        up_w_valid = '0; up_w_last = '0;
        repeat (2) @(posedge aclk);
        #1;
        areset_n = 1'b1;
        @(negedge aclk);
        chk("postrst_busy", {63'd0, busy}, 64'd0);
        both_burst(0, 32'h6000);

`ifdef AXI_WR_ARB_LEN_CHECK_EN
        // len=3 but w_last on beat 2 -> SLVERR upstream and one len_err pulse
        chk("len_err_quiet_before", 64'(len_err_cnt), 64'd0);
        push_burst(0, 32'h7000, 8'd3, 32'hE000_0000, 2, 2'b10);
        master_burst(0, 32'h7000, 8'd3, 32'hE000_0000, 2, 0);
        chk("len_err_pulses", 64'(len_err_cnt), 64'd1);
`endif

        repeat (3) @(posedge aclk);
        chk("drain_aw", 64'(exp_aw.size()), 64'd0);
        chk("drain_w", 64'(exp_w.size()), 64'd0);
        chk("drain_b", 64'(exp_b.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
